// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction fetch handshake with alignment and timeout checks
// Fetches the word at Address, holds it until decode accepts, then latches NPC.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] NPC,
    input  logic        Stall,
    input  logic        Instr_ready,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Address,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic [31:0] Instr_cnt,
    output logic        Misalign,
    output logic        Bus_err,
    output logic [31:0] Err_addr
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    // Counter value seen on the last WAIT cycle allowed before a bus error
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       accept;

    assign accept    = Instr_ready & ~Stall;
    assign imem_req  = (state == S_REQ);
    assign imem_addr = Address;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_REQ;
            wait_cnt    <= 8'd0;
            Address     <= RESET_PC;
            Instr       <= 32'd0;
            Instr_valid <= 1'b0;
            Instr_cnt   <= 32'd0;
            Misalign    <= 1'b0;
            Bus_err     <= 1'b0;
            Err_addr    <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // A response on the final allowed cycle still counts as on time
                    if (imem_rvalid) begin
                        Instr       <= imem_rdata;
                        Instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Bus_err  <= 1'b1;
                        Err_addr <= Address;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_VALID: begin
                    if (accept) begin
                        Instr_valid <= 1'b0;
                        Instr_cnt   <= Instr_cnt + 32'd1;
                        if (NPC[1:0] == 2'b00) begin
                            Address <= NPC;
                            state   <= S_REQ;
                        end else begin
                            Misalign <= 1'b1;
                            Err_addr <= NPC;
                            state    <= S_ERR;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit
// A transaction-level model predicts every output each cycle; literal checks pin key points.

module tb_pc_fetch_unit;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] NPC = 32'd0;
    logic        Stall = 1'b0;
    logic        Instr_ready = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Address;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] Instr_cnt;
    logic        Misalign;
    logic        Bus_err;
    logic [31:0] Err_addr;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .NPC(NPC), .Stall(Stall), .Instr_ready(Instr_ready),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .Address(Address), .Instr(Instr),
        .Instr_valid(Instr_valid), .Instr_cnt(Instr_cnt), .Misalign(Misalign),
        .Bus_err(Bus_err), .Err_addr(Err_addr)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Model phases: waiting to be granted, awaiting data, holding an instruction, dead
    localparam int P_ASK = 0, P_AWAIT = 1, P_HOLD = 2, P_DEAD = 3;
    int          m_phase;
    int          m_waited;
    logic [31:0] m_addr, m_instr, m_cnt, m_err_addr;
    logic        m_valid, m_mis, m_bus;

    function automatic void model_reset();
        m_phase = P_ASK; m_waited = 0;
        m_addr = RESET_PC; m_instr = 32'd0; m_cnt = 32'd0; m_err_addr = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0; m_bus = 1'b0;
    endfunction

    function automatic void model_step();
        if (m_phase == P_ASK) begin
            if (imem_gnt) begin m_phase = P_AWAIT; m_waited = 0; end
        end else if (m_phase == P_AWAIT) begin
            if (imem_rvalid) begin
                m_instr = imem_rdata; m_valid = 1'b1; m_phase = P_HOLD;
            end else if (m_waited + 1 == TIMEOUT) begin
                m_bus = 1'b1; m_err_addr = m_addr; m_phase = P_DEAD;
            end else begin
                m_waited++;
            end
        end else if (m_phase == P_HOLD) begin
            if (Instr_ready && !Stall) begin
                m_cnt = m_cnt + 1; m_valid = 1'b0;
                if (NPC % 4 == 0) begin m_addr = NPC; m_phase = P_ASK; end
                else begin m_mis = 1'b1; m_err_addr = NPC; m_phase = P_DEAD; end
            end
        end
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        n_vec++;
        cmp("imem_req", {31'd0, imem_req}, {31'd0, m_phase == P_ASK});
        cmp("imem_addr", imem_addr, m_addr);
        cmp("Address", Address, m_addr);
        cmp("Instr", Instr, m_instr);
        cmp("Instr_valid", {31'd0, Instr_valid}, {31'd0, m_valid});
        cmp("Instr_cnt", Instr_cnt, m_cnt);
        cmp("Misalign", {31'd0, Misalign}, {31'd0, m_mis});
        cmp("Bus_err", {31'd0, Bus_err}, {31'd0, m_bus});
        cmp("Err_addr", Err_addr, m_err_addr);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        cmp(name, act, exp);
    endtask

    // Called just after a falling edge: drive, clock once, predict, compare
    task automatic cycle(input logic g, input logic rv, input logic [31:0] d,
                         input logic rdy, input logic st, input logic [31:0] npc);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = d;
        Instr_ready = rdy; Stall = st; NPC = npc;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; Instr_ready = 1'b0; Stall = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_outputs();
    endtask

    // One complete fetch with noise on ignored inputs; rd < TIMEOUT keeps it on time
    task automatic run_fetch(input logic [31:0] npc, input int gd, input int rd,
                             input int sd, input logic [31:0] data);
        repeat (gd) cycle(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
        cycle(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
        repeat (rd) cycle(1'($urandom), 1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom);
        cycle(1'($urandom), 1'b1, data, 1'b0, 1'b0, npc);
        repeat (sd) cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'b1, npc);
        cycle(1'($urandom), 1'($urandom), $urandom, 1'b1, 1'b0, npc);
    endtask

    initial begin
        int          waited;
        logic [31:0] held_cnt;
        logic [31:0] held_instr;
        logic [31:0] rnpc;

        // Reset values
        model_reset();
        @(negedge Clk);
        #1;
        check_outputs();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        lit("reset_address", Address, 32'h0000_3000);
        lit("reset_req", {31'd0, imem_req}, 32'd1);
        lit("reset_cnt", Instr_cnt, 32'd0);

        // First fetch: grant, data, accept to 0x3004
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h3004);
        cycle(1'b0, 1'b1, 32'h2002_0005, 1'b1, 1'b0, 32'h3004);
        lit("first_instr", Instr, 32'h2002_0005);
        lit("first_valid", {31'd0, Instr_valid}, 32'd1);
        lit("first_addr_held", Address, 32'h0000_3000);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h3004);
        lit("first_addr_next", Address, 32'h0000_3004);
        lit("first_cnt", Instr_cnt, 32'd1);
        lit("first_req_again", {31'd0, imem_req}, 32'd1);

        // Stall holds the instruction for five cycles
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h3008);
        cycle(1'b0, 1'b1, 32'hDEAD_0004, 1'b0, 1'b0, 32'h3008);
        held_cnt = Instr_cnt;
        held_instr = Instr;
        repeat (5) cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b1, 32'h3008);
        lit("stall_cnt", Instr_cnt, held_cnt);
        lit("stall_instr", Instr, held_instr);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h3008);
        lit("stall_accept_addr", Address, 32'h0000_3008);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h300C);
        lit("stall_single_accept", Instr_cnt, 32'd2);

        // Misaligned NPC sends the unit to its absorbing error state
        do_reset();
        run_fetch(32'h3006, 0, 0, 0, 32'h1111_2222);
        lit("mis_flag", {31'd0, Misalign}, 32'd1);
        lit("mis_err_addr", Err_addr, 32'h0000_3006);
        lit("mis_address", Address, 32'h0000_3000);
        repeat (6) cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
        lit("mis_req_low", {31'd0, imem_req}, 32'd0);

        // Withheld response times out after exactly TIMEOUT WAIT cycles
        do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        waited = 0;
        while (!Bus_err && waited < 100) begin
            cycle(1'($urandom), 1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom);
            waited++;
        end
        lit("timeout_cycles", waited, 32'd16);
        lit("timeout_err_addr", Err_addr, 32'h0000_3000);
        repeat (4) cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
        lit("timeout_sticky", {31'd0, Bus_err}, 32'd1);

        // Response on the final WAIT cycle is still accepted
        do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (TIMEOUT - 1) cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'd0);
        lit("late_no_err", {31'd0, Bus_err}, 32'd0);
        lit("late_instr", Instr, 32'hA5A5_0001);

        // Asynchronous reset in the middle of a WAIT at 0x3010
        do_reset();
        for (int i = 0; i < 4; i++) run_fetch(m_addr + 32'd4, 0, 1, 0, $urandom);
        lit("pre_reset_addr", Address, 32'h0000_3010);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        lit("async_addr", Address, 32'h0000_3000);
        lit("async_cnt", Instr_cnt, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_outputs();
        lit("async_req", {31'd0, imem_req}, 32'd1);

        // 100 back-to-back sequential fetches with random handshake delays
        do_reset();
        for (int i = 0; i < 100; i++)
            run_fetch(m_addr + 32'd4, $urandom_range(0, 3), $urandom_range(0, 5),
                      $urandom_range(0, 2), $urandom);
        lit("seq_cnt", Instr_cnt, 32'd100);
        lit("seq_addr", Address, 32'h0000_3190);
        lit("seq_no_bus", {31'd0, Bus_err}, 32'd0);
        lit("seq_no_mis", {31'd0, Misalign}, 32'd0);

        // Free-running random traffic, resetting whenever the model dies
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rnpc = {$urandom_range(0, 32'h000F_FFFF), 2'b00} + 32'h3000;
            if ($urandom_range(0, 11) == 0) rnpc[1:0] = 2'($urandom_range(1, 3));
            cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), $urandom,
                  1'($urandom), 1'($urandom_range(0, 3) == 0), rnpc);
            if (m_phase == P_DEAD && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
